// File: rtl/multichannel_level_meter.sv
// Time-multiplexed level meter: per-channel windowed DC mean, DC-corrected peak,
// mean-square power and clip detection over 2^WINDOW_BITS samples per channel.
module multichannel_level_meter #(
  parameter int DATA_WIDTH  = 16,
  parameter int CHANNELS    = 4,
  parameter int WINDOW_BITS = 20,
  localparam int CH_BITS    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      clear,
  input  logic                      in_valid,
  input  logic [CH_BITS-1:0]        in_channel,
  input  logic [DATA_WIDTH-1:0]     in_data,
  output logic                      out_valid,
  output logic [CH_BITS-1:0]        out_channel,
  output logic [DATA_WIDTH-1:0]     out_dc,
  output logic [DATA_WIDTH-1:0]     out_peak,
  output logic [2*DATA_WIDTH-1:0]   out_power,
  output logic                      out_clip
);
  localparam int DW  = DATA_WIDTH;
  localparam int WB  = WINDOW_BITS;
  localparam int S1W = DW + WB;
  localparam int S2W = 2 * DW + WB;

  localparam logic signed [DW:0]  AC_MAX = {2'b00, {(DW-1){1'b1}}};
  localparam logic signed [DW:0]  AC_MIN = ~AC_MAX + (DW+1)'(1);
  localparam logic signed [S1W:0] DC_MAX = {{(S1W+2-DW){1'b0}}, {(DW-1){1'b1}}};
  localparam logic signed [S1W:0] DC_MIN = ~DC_MAX;
  localparam logic [DW-1:0]       RAW_MAX = {1'b0, {(DW-1){1'b1}}};
  localparam logic [DW-1:0]       RAW_MIN = {1'b1, {(DW-1){1'b0}}};

  function automatic logic signed [DW-1:0] sat_ac(input logic signed [DW:0] x);
    if (x > AC_MAX) return AC_MAX[DW-1:0];
    else if (x < AC_MIN) return AC_MIN[DW-1:0];
    else return x[DW-1:0];
  endfunction

  // Round-half-up divide by the window length, clamped to the sample range.
  function automatic logic signed [DW-1:0] round_dc(input logic signed [S1W-1:0] total);
    logic signed [S1W:0] r;
    r = $signed({total[S1W-1], total});
    r = (r >>> WB) + $signed({{S1W{1'b0}}, total[WB-1]});
    if (r > DC_MAX) return DC_MAX[DW-1:0];
    else if (r < DC_MIN) return DC_MIN[DW-1:0];
    else return r[DW-1:0];
  endfunction

  function automatic logic [2*DW-1:0] round_pw(input logic [S2W-1:0] s);
    logic [S2W-1:0] t;
    t = (s >> WB) + S2W'(s[WB-1]);
    return t[2*DW-1:0];
  endfunction

  logic signed [DW-1:0]  dc_r   [CHANNELS];
  logic [WB-1:0]         cnt_r  [CHANNELS];
  logic signed [S1W-1:0] sum1_r [CHANNELS];
  logic [S2W-1:0]        sum2_r [CHANNELS];
  logic [DW-1:0]         max_r  [CHANNELS];
  logic                  clip_r [CHANNELS];

  logic                  acc;
  logic                  last_in;
  logic signed [DW-1:0]  dc_cur;
  logic signed [S1W-1:0] total;
  logic signed [DW:0]    ac_wide;
  logic                  raw_clip;

  assign acc      = in_valid && !clear && ({1'b0, in_channel} < (CH_BITS+1)'(CHANNELS));
  assign dc_cur   = dc_r[in_channel];
  assign last_in  = (cnt_r[in_channel] == {WB{1'b1}});
  assign total    = sum1_r[in_channel] + $signed({{WB{in_data[DW-1]}}, in_data});
  assign ac_wide  = $signed({in_data[DW-1], in_data}) - $signed({dc_cur[DW-1], dc_cur});
  assign raw_clip = (in_data == RAW_MAX) || (in_data == RAW_MIN);

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int c = 0; c < CHANNELS; c++) begin
        dc_r[c]   <= '0;
        cnt_r[c]  <= '0;
        sum1_r[c] <= '0;
      end
    end else if (clear) begin
      for (int c = 0; c < CHANNELS; c++) begin
        cnt_r[c]  <= '0;
        sum1_r[c] <= '0;
      end
    end else if (acc) begin
      cnt_r[in_channel]  <= cnt_r[in_channel] + WB'(1);
      sum1_r[in_channel] <= last_in ? '0 : total;
      if (last_in) dc_r[in_channel] <= round_dc(total);
    end
  end

  // Stage p0: DC subtraction and saturation
  logic                 vld_p0, last_p0, clip_p0;
  logic [CH_BITS-1:0]   ch_p0;
  logic signed [DW-1:0] ac_p0, dc_p0;

  // Stage p1: magnitude and square
  logic                 vld_p1, last_p1, clip_p1;
  logic [CH_BITS-1:0]   ch_p1;
  logic [DW-1:0]        mag_p1;
  logic [2*DW-1:0]      sq_p1;
  logic signed [DW-1:0] dc_p1;

  // Stage p2: window totals of a completed window
  logic                 vld_p2, clip_p2;
  logic [CH_BITS-1:0]   ch_p2;
  logic [DW-1:0]        pk_p2;
  logic [S2W-1:0]       s2_p2;
  logic signed [DW-1:0] dc_p2;

  logic [S2W-1:0] s2_next;
  logic [DW-1:0]  pk_next;
  logic           cl_next;

  assign s2_next = sum2_r[ch_p1] + S2W'(sq_p1);
  assign pk_next = (mag_p1 > max_r[ch_p1]) ? mag_p1 : max_r[ch_p1];
  assign cl_next = clip_r[ch_p1] | clip_p1;

  always_ff @(posedge clock) begin
    if (reset || clear) begin
      vld_p0 <= 1'b0;
      vld_p1 <= 1'b0;
      vld_p2 <= 1'b0;
    end else begin
      vld_p0 <= acc;
      vld_p1 <= vld_p0;
      vld_p2 <= vld_p1 && last_p1;
    end
  end

  always_ff @(posedge clock) begin
    ch_p0   <= in_channel;
    ac_p0   <= sat_ac(ac_wide);
    clip_p0 <= raw_clip;
    last_p0 <= last_in;
    dc_p0   <= round_dc(total);

    ch_p1   <= ch_p0;
    mag_p1  <= ac_p0[DW-1] ? DW'(-ac_p0) : ac_p0;
    sq_p1   <= ac_p0 * ac_p0;
    clip_p1 <= clip_p0;
    last_p1 <= last_p0;
    dc_p1   <= dc_p0;

    ch_p2   <= ch_p1;
    pk_p2   <= pk_next;
    s2_p2   <= s2_next;
    clip_p2 <= cl_next;
    dc_p2   <= dc_p1;
  end

  // Each accumulator is read and rewritten in one cycle, so same-channel
  // samples on consecutive edges always see the previous update.
  always_ff @(posedge clock) begin
    if (reset || clear) begin
      for (int c = 0; c < CHANNELS; c++) begin
        sum2_r[c] <= '0;
        max_r[c]  <= '0;
        clip_r[c] <= 1'b0;
      end
    end else if (vld_p1) begin
      sum2_r[ch_p1] <= last_p1 ? '0 : s2_next;
      max_r[ch_p1]  <= last_p1 ? '0 : pk_next;
      clip_r[ch_p1] <= last_p1 ? 1'b0 : cl_next;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      out_valid   <= 1'b0;
      out_channel <= '0;
      out_dc      <= '0;
      out_peak    <= '0;
      out_power   <= '0;
      out_clip    <= 1'b0;
    end else if (clear) begin
      out_valid <= 1'b0;
    end else begin
      out_valid <= vld_p2;
      if (vld_p2) begin
        out_channel <= ch_p2;
        out_dc      <= dc_p2;
        out_peak    <= pk_p2;
        out_power   <= round_pw(s2_p2);
        out_clip    <= clip_p2;
      end
    end
  end
endmodule

// File: tb/tb_multichannel_level_meter.sv
// Directed bench for multichannel_level_meter with DW=16, CHANNELS=2, WINDOW_BITS=2.
module tb_multichannel_level_meter;
  logic        clock = 1'b0;
  logic        reset, clear, in_valid;
  logic [0:0]  in_channel;
  logic [15:0] in_data;
  logic        out_valid;
  logic [0:0]  out_channel;
  logic [15:0] out_dc, out_peak;
  logic [31:0] out_power;
  logic        out_clip;

  int total = 0;
  int bad = 0;
  int nstrobe = 0;
  int snap;

  multichannel_level_meter #(.DATA_WIDTH(16), .CHANNELS(2), .WINDOW_BITS(2)) dut (
    .clock(clock), .reset(reset), .clear(clear), .in_valid(in_valid),
    .in_channel(in_channel), .in_data(in_data), .out_valid(out_valid),
    .out_channel(out_channel), .out_dc(out_dc), .out_peak(out_peak),
    .out_power(out_power), .out_clip(out_clip));

  always #5 clock = ~clock;

  always @(negedge clock) if (out_valid === 1'b1) nstrobe++;

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic send(input logic ch, input int d);
    in_valid   = 1'b1;
    in_channel = ch;
    in_data    = d[15:0];
    tick();
    in_valid   = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic check_result(input string tag, input logic ch, input int dc, input int pk,
                              input int pw, input logic cl);
    logic [15:0] edc;
    logic [15:0] epk;
    edc = dc[15:0];
    epk = pk[15:0];
    chk({tag, "_valid"}, 64'(out_valid), 64'(1'b1));
    chk({tag, "_ch"},    64'(out_channel), 64'(ch));
    chk({tag, "_dc"},    64'(out_dc), 64'(edc));
    chk({tag, "_peak"},  64'(out_peak), 64'(epk));
    chk({tag, "_power"}, 64'(out_power), 64'(pw));
    chk({tag, "_clip"},  64'(out_clip), 64'(cl));
  endtask

  // Final sample was just accepted; strobe must appear on the third edge only.
  task automatic expect_strobe(input string tag, input logic ch, input int dc, input int pk,
                               input int pw, input logic cl);
    tick();
    chk({tag, "_early1"}, 64'(out_valid), 64'(1'b0));
    tick();
    chk({tag, "_early2"}, 64'(out_valid), 64'(1'b0));
    tick();
    check_result(tag, ch, dc, pk, pw, cl);
    tick();
    chk({tag, "_oneshot"}, 64'(out_valid), 64'(1'b0));
    chk({tag, "_hold"}, 64'(out_power), 64'(pw));
  endtask

  initial begin
    reset = 1'b1; clear = 1'b0; in_valid = 1'b0; in_channel = '0; in_data = '0;
    tick();
    tick();
    reset = 1'b0;
    chk("rst_valid", 64'(out_valid), 64'(1'b0));
    chk("rst_dc",    64'(out_dc), 64'(0));
    chk("rst_power", 64'(out_power), 64'(0));

    // Steady DC: first window measures it, second sees nothing left over
    for (int i = 0; i < 4; i++) send(1'b0, 100);
    expect_strobe("dc_win1", 1'b0, 100, 100, 10000, 1'b0);
    for (int i = 0; i < 4; i++) send(1'b0, 100);
    expect_strobe("dc_win2", 1'b0, 100, 0, 0, 1'b0);

    // Rounding of the mean
    do_reset();
    send(1'b0, 2); send(1'b0, 0); send(1'b0, 0); send(1'b0, 0);
    expect_strobe("rnd_2", 1'b0, 1, 2, 1, 1'b0);
    send(1'b0, 1); send(1'b0, 0); send(1'b0, 0); send(1'b0, 0);
    expect_strobe("rnd_1", 1'b0, 0, 1, 1, 1'b0);
    send(1'b0, -2); send(1'b0, 0); send(1'b0, 0); send(1'b0, 0);
    expect_strobe("rnd_m2", 1'b0, 0, 2, 1, 1'b0);

    // Full-scale samples: clip flag and ac saturation
    do_reset();
    send(1'b1, 32767); send(1'b1, 0); send(1'b1, 0); send(1'b1, 0);
    expect_strobe("clip_pos", 1'b1, 8192, 32767, 268419072, 1'b1);
    do_reset();
    send(1'b1, -32768); send(1'b1, 0); send(1'b1, 0); send(1'b1, 0);
    expect_strobe("clip_neg", 1'b1, -8192, 32767, 268419072, 1'b1);

    // Interleaved channels: ch0 completes one edge before ch1
    do_reset();
    for (int i = 0; i < 4; i++) begin
      send(1'b0, 10);
      send(1'b1, -20);
    end
    tick();
    chk("ilv_early", 64'(out_valid), 64'(1'b0));
    tick();
    check_result("ilv_ch0", 1'b0, 10, 10, 100, 1'b0);
    tick();
    check_result("ilv_ch1", 1'b1, -20, 20, 400, 1'b0);
    tick();
    chk("ilv_end", 64'(out_valid), 64'(1'b0));

    // Back-to-back same-channel samples
    do_reset();
    send(1'b0, 1); send(1'b0, 2); send(1'b0, 3); send(1'b0, 4);
    expect_strobe("b2b", 1'b0, 3, 4, 8, 1'b0);

    // Reset mid-window discards the partial window and zeroes outputs
    snap = nstrobe;
    send(1'b0, 9); send(1'b0, 9); send(1'b0, 9);
    do_reset();
    chk("mid_rst_dc", 64'(out_dc), 64'(0));
    for (int i = 0; i < 4; i++) send(1'b0, 5);
    expect_strobe("mid_rst", 1'b0, 5, 5, 25, 1'b0);
    tick(); tick(); tick();
    chk("mid_rst_count", 64'(nstrobe), 64'(snap + 1));

    // Clear mid-window keeps dc and outputs; the sample presented with clear is dropped
    snap = nstrobe;
    send(1'b0, 7); send(1'b0, 7); send(1'b0, 7);
    clear = 1'b1; in_valid = 1'b1; in_channel = 1'b0; in_data = 16'd9;
    tick();
    clear = 1'b0; in_valid = 1'b0;
    chk("clr_hold_dc", 64'(out_dc), 64'(5));
    for (int i = 0; i < 6; i++) tick();
    chk("clr_no_strobe", 64'(nstrobe), 64'(snap));
    for (int i = 0; i < 4; i++) send(1'b0, 5);
    expect_strobe("clr_win", 1'b0, 5, 0, 0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/multichannel_level_meter.md
MULTICHANNEL_LEVEL_METER -- requirements
Module: multichannel_level_meter

Interface
REQ-001 Parameter DATA_WIDTH, default 16, signed sample width (minimum 8).
REQ-002 Parameter CHANNELS, default 4, number of time-multiplexed channels (power of two, 1 to 16).
REQ-003 Parameter WINDOW_BITS, default 20, integration window of 2^WINDOW_BITS samples per channel (minimum 2).
REQ-004 Local CH_BITS = max(1, log2(CHANNELS)).
REQ-005 clock  in  1  sole clock; all logic on the rising edge.
REQ-006 reset  in  1  synchronous, active-high reset.
REQ-007 clear  in  1  synchronous restart of all windows; DC estimates are retained.
REQ-008 in_valid  in  1  in_data/in_channel are accepted on this edge; no backpressure.
REQ-009 in_channel  in  CH_BITS  channel tag of the sample.
REQ-010 in_data  in  DATA_WIDTH  signed sample.
REQ-011 out_valid  out  1  one-cycle result strobe.
REQ-012 out_channel  out  CH_BITS  channel of the result.
REQ-013 out_dc  out  DATA_WIDTH  signed window mean.
REQ-014 out_peak  out  DATA_WIDTH  unsigned peak of the DC-corrected magnitude.
REQ-015 out_power  out  2*DATA_WIDTH  unsigned mean square of the DC-corrected sample.
REQ-016 out_clip  out  1  some raw sample in the window equalled -2^(DW-1) or 2^(DW-1)-1.

Function
REQ-017 Per channel state: dc, sample count (WINDOW_BITS bits), sum1 (signed, DW+WINDOW_BITS bits), sum2 (unsigned, 2*DW+WINDOW_BITS bits), max, clip flag.
REQ-018 The sample is ac = in_data - dc[ch], computed at DW+1 bits and saturated to [-(2^(DW-1)-1), 2^(DW-1)-1].
REQ-019 Magnitude is |ac|; the square is ac*ac (at most 2*DW-2 bits).
REQ-020 sum1 accumulates raw in_data with no pipeline, and is updated on the accepting edge.
REQ-021 max, sum2 and clip are updated through a 3-stage pipeline: subtract/saturate, abs/square, accumulate.
REQ-022 Back-to-back or interleaved samples of the same channel shall all be accumulated; no update is lost (forwarding is required).
REQ-023 The window's final sample is the one accepted when count[ch] = 2^WINDOW_BITS-1; count then wraps to 0.
REQ-024 dc[ch] is loaded on the accepting edge of the final sample with round(sum1_total/2^WINDOW_BITS).
  - Formula: sum1_total arithmetic-shifted right by WINDOW_BITS, plus bit WINDOW_BITS-1.
  - Saturated to the signed DW range.
REQ-025 The final sample itself uses the old dc; the next accepted sample of that channel uses the new dc.
REQ-026 out_valid is high for exactly one cycle, 3 edges after the edge accepting the final sample.
  - out_dc is the dc value loaded per REQ-024.
  - out_peak is the window max.
  - out_power is the rounded shift of sum2 (same rounding as REQ-024).
  - out_clip is the window clip flag.
REQ-027 Outputs hold their values between strobes.
REQ-028 At most one result is produced per cycle; no queueing is needed because only one sample is accepted per cycle.
REQ-029 The accumulators of the completed window restart at zero for the next sample, with no sample dropped across the boundary.
REQ-030 in_channel >= CHANNELS is ignored (sample discarded, no state change).

Reset
REQ-031 reset zeroes:
  - all per-channel state, including dc;
  - the pipeline valids;
  - out_valid, out_channel, out_dc, out_peak, out_power and out_clip.
REQ-032 clear zeroes counts, sums, max, clip and the pipeline valids.
  - dc and the outputs are kept.
  - A sample presented on the same edge is discarded.
  - No out_valid occurs for windows that are in flight.
REQ-033 When reset and clear are asserted together, reset takes priority.
REQ-034 reset or clear mid-window shall never produce a partial-window result.

Verification (DW=16, CHANNELS=2, WINDOW_BITS=2)
REQ-035 Ch0 with in_data 100 x4 -> out_valid 3 edges after the 4th sample; dc=100, peak=100, power=10000, clip=0. A second window of 100 x4 -> dc=100, peak=0, power=0.
REQ-036 Rounding: ch0 with 2,0,0,0 -> out_dc=1; with 1,0,0,0 -> out_dc=0; with -2,0,0,0 -> out_dc=0 (-1 + 1).
REQ-037 Interleave: ch0/ch1 alternate each cycle (ch0=10, ch1=-20) x8 edges -> two strobes on consecutive cycles: ch0 (dc 10, peak 10, power 100), then ch1 (dc -20, peak 20, power 400).
REQ-038 Ch1 with 32767,0,0,0 -> clip=1, peak=32767. With dc=0, -32768 saturates ac to -32767 -> peak 32767, power 1073676289>>2 with rounding = 268419072.
REQ-039 Mid-window reset: ch0 with 3 samples, reset for 1 cycle, then 4 samples of 5 -> exactly one strobe with dc=5, peak=5, power=25. clear after 3 samples -> prior dc retained, no strobe until 4 new samples.
REQ-040 Back-to-back ch0 samples 1,2,3,4 on consecutive edges -> peak=4, power=round(30/4)=8, dc=round(10/4)=3.
